sync_word_serializer: RTL and testbench
=======================================

Name: sync_word_serializer

Overview:
- Transmit-side counterpart of the 12-bit sync-word sequence detector with 2-bit error tolerance.
- On request, serializes PATTERN MSB-first onto a 1-bit line, one bit per clock.
- Optionally XORs a latched error mask into every transmitted frame to exercise the receiver's error tolerance.
- Supports bursts of back-to-back frames separated by a fixed idle gap. Used as a stimulus source and as the framing transmitter in link bring-up.

Parameters:
- WIDTH, 12, frame length in bits.
- PATTERN, 12'b111000101011, sync word; transmitted MSB first.
- GAP, 2, idle bit-times inserted between consecutive frames of a burst. 0 means frames are back-to-back.
- IDLE_BIT, 1'b0, level driven on o_data whenever no frame bit is being sent.
- CNT_W, 8, width of the burst-count input and the frames-sent counter.

Ports:
- i_clk, input, 1, system clock; all state changes on the rising edge.
- i_reset, input, 1, asynchronous, active-high reset.
- i_start, input, 1, burst request; sampled only in IDLE.
- i_repeat, input, CNT_W, number of frames in the burst; sampled with i_start. A value of 0 is treated as 1.
- i_err_mask, input, WIDTH, error-injection mask; sampled with i_start. Bit k set inverts transmitted bit k (bit WIDTH-1 is sent first).
- i_abort, input, 1, terminates the burst at the next edge.
- o_data, output, 1, serial data, registered.
- o_valid, output, 1, high while o_data carries a frame bit.
- o_busy, output, 1, high whenever state is not IDLE.
- o_frame_done, output, 1, single-cycle pulse coincident with the last bit of each completed frame.
- o_frames_sent, output, CNT_W, frames completed since the last accepted i_start; saturates at all-ones.
- o_err_bits, output, $clog2(WIDTH+1), population count of the latched mask. For the default WIDTH=12 this is 4 bits.

Behaviour:
- Reset (i_reset high, asynchronous): state IDLE; o_data=IDLE_BIT, o_valid=0, o_busy=0, o_frame_done=0, o_frames_sent=0, o_err_bits=0.
  - Internal shift register, bit counter and frame counter cleared.
  - Reset asserted mid-burst terminates the burst immediately; no o_frame_done is issued.
- State machine: IDLE, SEND, GAP.
- IDLE, i_start=1 at edge t:
  - Latch i_repeat (0 becomes 1) and i_err_mask.
  - Load shift register with PATTERN ^ mask; clear o_frames_sent.
  - Go to SEND, and in the same edge register the first bit: o_data=PATTERN[WIDTH-1]^mask[WIDTH-1], o_valid=1, o_busy=1.
  - Latency from the start-sampling edge to the first bit is 0 cycles (bit visible right after edge t).
  - o_err_bits is updated at edge t and holds until the next accepted start or reset.
- SEND:
  - Shift left one bit per cycle; exactly WIDTH consecutive cycles with o_valid=1.
  - On the edge that presents bit 0: o_frame_done=1 in that same cycle.
  - o_frames_sent increments at the edge following the last bit (saturating).
  - After the last bit:
    - More frames remain and GAP>0: go to GAP.
    - More frames remain and GAP=0: reload the shift register and continue SEND with no bubble.
    - Final frame: go to IDLE.
- GAP: exactly GAP cycles with o_valid=0 and o_data=IDLE_BIT, then reload the same masked pattern and enter SEND. No gap follows the final frame.
- i_start while o_busy=1 is ignored. It does not queue and does not alter the latched mask or count.
- i_abort (any non-IDLE state) at edge t: go to IDLE; o_valid=0, o_data=IDLE_BIT, o_frame_done=0, o_busy=0 after edge t. o_frames_sent keeps its completed count.
- i_abort and i_start together in IDLE: start wins; abort has no effect in IDLE.
- Burst duration: N*WIDTH + (N-1)*GAP cycles of o_busy=1, where N is the effective repeat count.

Test Plan:
- Reset, then i_start with i_repeat=1, mask=0 -> o_data sequence 1,1,1,0,0,0,1,0,1,0,1,1 with o_valid high for 12 cycles; o_frame_done high on the 12th bit; o_frames_sent=1; o_err_bits=0; o_busy low after the 12th bit.
- i_start with mask=12'h001, then mask=12'h802 -> frame 111000101010 with o_err_bits=1; frame 011000101001 with o_err_bits=2.
- i_repeat=3, GAP=2 -> 40 busy cycles; valid pattern 12 on, 2 off, 12 on, 2 off, 12 on; three o_frame_done pulses; o_frames_sent=3. Repeat with GAP=0 -> 36 contiguous valid cycles.
- i_repeat=0 -> exactly one frame. i_start pulsed during bit 5 with a different mask -> ignored; the original mask is applied to all remaining frames.
- i_abort during bit 7 of frame 2 of a 3-frame burst -> next cycle o_valid=0, o_data=0, o_busy=0, no o_frame_done, o_frames_sent=1.
- i_reset asserted asynchronously between clock edges mid-frame -> all outputs reach reset values before the next edge; a new i_start after release produces a clean frame.

Source files
------------

// File: rtl/sync_word_serializer.sv
// Sync-word serializer: sends PATTERN MSB-first, optionally XOR-masked,
// in bursts of frames separated by a fixed idle gap.
module sync_word_serializer #(
    parameter int              WIDTH    = 12,
    parameter logic [WIDTH-1:0] PATTERN = 12'b111000101011,
    parameter int              GAP      = 2,
    parameter logic            IDLE_BIT = 1'b0,
    parameter int              CNT_W    = 8,
    localparam int             EB       = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_repeat,
    input  logic [WIDTH-1:0] i_err_mask,
    input  logic             i_abort,
    output logic             o_data,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic [CNT_W-1:0] o_frames_sent,
    output logic [EB-1:0]    o_err_bits
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic ONE_BIT = (WIDTH == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_shift, w_shift;
    logic [BW-1:0]    r_bitcnt, w_bitcnt;
    logic [GW-1:0]    r_gapcnt, w_gapcnt;
    logic [CNT_W-1:0] r_rem, w_rem;
    logic [WIDTH-1:0] r_mask, w_mask;
    logic             r_data, w_data;
    logic             r_done, w_done;
    logic [CNT_W-1:0] r_frames, w_frames;
    logic [EB-1:0]    r_errbits, w_errbits;
    logic [EB-1:0]    w_popcnt;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_new_word;

    assign w_word     = PATTERN ^ r_mask;
    assign w_new_word = PATTERN ^ i_err_mask;

    // Population count of the incoming mask, latched on an accepted start
    always_comb begin
        w_popcnt = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w_popcnt = w_popcnt + EB'(i_err_mask[k]);
        end
    end

    // Next-state and datapath: first bit of each frame leaves on its load edge
    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_bitcnt  = r_bitcnt;
        w_gapcnt  = r_gapcnt;
        w_rem     = r_rem;
        w_mask    = r_mask;
        w_data    = r_data;
        w_done    = 1'b0;
        w_frames  = r_frames;
        w_errbits = r_errbits;
        unique case (r_state)
            S_IDLE: begin
                w_data = IDLE_BIT;
                if (i_start) begin
                    w_mask    = i_err_mask;
                    w_rem     = (i_repeat == '0) ? CNT_W'(1) : i_repeat;
                    w_frames  = '0;
                    w_errbits = w_popcnt;
                    w_state   = S_SEND;
                    w_data    = w_new_word[WIDTH-1];
                    w_shift   = w_new_word << 1;
                    w_bitcnt  = LAST_IDX;
                    w_done    = ONE_BIT;
                end
            end
            S_SEND: begin
                if (i_abort) begin
                    w_state = S_IDLE;
                    w_data  = IDLE_BIT;
                end else if (r_bitcnt != '0) begin
                    w_data   = r_shift[WIDTH-1];
                    w_shift  = r_shift << 1;
                    w_bitcnt = r_bitcnt - 1'b1;
                    w_done   = (r_bitcnt == BW'(1));
                end else begin
                    w_frames = (&r_frames) ? r_frames
                                           : r_frames + 1'b1;
                    w_rem    = r_rem - 1'b1;
                    if (r_rem <= CNT_W'(1)) begin
                        w_state = S_IDLE;
                        w_data  = IDLE_BIT;
                    end else if (GAP > 0) begin
                        w_state  = S_GAP;
                        w_data   = IDLE_BIT;
                        w_gapcnt = GAP_LOAD;
                    end else begin
                        w_data   = w_word[WIDTH-1];
                        w_shift  = w_word << 1;
                        w_bitcnt = LAST_IDX;
                        w_done   = ONE_BIT;
                    end
                end
            end
            S_GAP: begin
                w_data = IDLE_BIT;
                if (i_abort) begin
                    w_state = S_IDLE;
                end else if (r_gapcnt == '0) begin
                    w_state  = S_SEND;
                    w_data   = w_word[WIDTH-1];
                    w_shift  = w_word << 1;
                    w_bitcnt = LAST_IDX;
                    w_done   = ONE_BIT;
                end else begin
                    w_gapcnt = r_gapcnt - 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_data  = IDLE_BIT;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_gapcnt  <= '0;
            r_rem     <= '0;
            r_mask    <= '0;
            r_data    <= IDLE_BIT;
            r_done    <= 1'b0;
            r_frames  <= '0;
            r_errbits <= '0;
        end else begin
            r_state   <= w_state;
            r_shift   <= w_shift;
            r_bitcnt  <= w_bitcnt;
            r_gapcnt  <= w_gapcnt;
            r_rem     <= w_rem;
            r_mask    <= w_mask;
            r_data    <= w_data;
            r_done    <= w_done;
            r_frames  <= w_frames;
            r_errbits <= w_errbits;
        end
    end

    assign o_data        = r_data;
    assign o_valid       = (r_state == S_SEND);
    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_done  = r_done;
    assign o_frames_sent = r_frames;
    assign o_err_bits    = r_errbits;

endmodule

// File: tb/tb_sync_word_serializer.sv
// Bench for sync_word_serializer: vector table plus scoreboard of
// expected per-cycle {busy,valid,data,done} and hand-written corner cases.
module tb_sync_word_serializer;

    localparam int W = 12;
    localparam logic [W-1:0] PAT = 12'b111000101011;
    localparam int GAPC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] rep;
    logic [W-1:0] mask;

    logic       data, valid, busy, done;
    logic [7:0] frames;
    logic [3:0] errb;
    logic       data0, valid0, busy0, done0;
    logic [7:0] frames0;
    logic [3:0] errb0;

    always #5 clk = ~clk;

    sync_word_serializer dut (
        .i_clk(clk), .i_reset(rst), .i_start(start),
        .i_repeat(rep), .i_err_mask(mask), .i_abort(abort),
        .o_data(data), .o_valid(valid), .o_busy(busy),
        .o_frame_done(done), .o_frames_sent(frames),
        .o_err_bits(errb)
    );

    sync_word_serializer #(.GAP(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_start(start),
        .i_repeat(rep), .i_err_mask(mask), .i_abort(abort),
        .o_data(data0), .o_valid(valid0), .o_busy(busy0),
        .o_frame_done(done0), .o_frames_sent(frames0),
        .o_err_bits(errb0)
    );

    int checks = 0;
    int errors = 0;
    logic [3:0] q[$];
    bit mon_en = 1'b0;
    bit cnt_en = 1'b0;
    int v0cnt, run0, maxrun0, d0cnt, bcnt;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected output stream of one burst as seen by the GAP=2 instance
    task automatic push_burst(logic [7:0] r, logic [W-1:0] m);
        int n;
        logic [W-1:0] word;
        n = (r == 0) ? 1 : int'(r);
        word = PAT ^ m;
        for (int f = 0; f < n; f++) begin
            for (int b = W - 1; b >= 0; b--)
                q.push_back({1'b1, 1'b1, word[b], (b == 0)});
            if (f < n - 1)
                for (int g = 0; g < GAPC; g++)
                    q.push_back(4'b1000);
        end
    endtask

    // Per-cycle comparison against the scoreboard; empty means idle
    always @(negedge clk) begin : mon
        logic [3:0] e;
        if (mon_en) begin
            e = (q.size() > 0) ? q.pop_front() : 4'b0000;
            chk("stream", {28'd0, busy, valid, data, done}, {28'd0, e});
        end
    end

    // Activity counters used by the GAP=0 and burst-length checks
    always @(negedge clk) begin
        if (cnt_en) begin
            v0cnt += int'(valid0);
            run0 = valid0 ? run0 + 1 : 0;
            if (run0 > maxrun0) maxrun0 = run0;
            d0cnt += int'(done0);
            bcnt += int'(busy);
        end
    end

    task automatic start_burst(logic [7:0] r, logic [W-1:0] m);
        @(negedge clk);
        #1;
        start = 1'b1;
        rep = r;
        mask = m;
        push_burst(r, m);
        @(negedge clk);
        #1;
        start = 1'b0;
        rep = 8'd0;
        mask = '0;
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (q.size() > 0 && i < 300) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]   rep;
        logic [W-1:0] mask;
        int           exp_err;
        int           exp_frames;
    } vec_t;

    vec_t tv[7];

    initial begin
        tv[0] = '{8'd1, 12'h000, 0, 1};
        tv[1] = '{8'd1, 12'h001, 1, 1};
        tv[2] = '{8'd1, 12'h802, 2, 1};
        tv[3] = '{8'd3, 12'h000, 0, 3};
        tv[4] = '{8'd0, 12'h000, 0, 1};
        tv[5] = '{8'd2, 12'hFFF, 12, 2};
        tv[6] = '{8'd4, 12'h0F0, 4, 4};

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        rep = 8'd0;
        mask = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {busy, valid, data, done}, 4'b0000);
        chk("reset_frames", frames, 0);
        chk("reset_errbits", errb, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            start_burst(tv[i].rep, tv[i].mask);
            wait_drain();
            chk($sformatf("v%0d_errbits", i), errb, tv[i].exp_err);
            chk($sformatf("v%0d_frames", i), frames, tv[i].exp_frames);
        end

        // Three frames: 40 busy cycles here, 36 contiguous bits with GAP=0
        v0cnt = 0; run0 = 0; maxrun0 = 0; d0cnt = 0; bcnt = 0;
        @(negedge clk);
        #1;
        cnt_en = 1'b1;
        start_burst(8'd3, 12'h000);
        wait_drain();
        cnt_en = 1'b0;
        chk("gap2_busy_cycles", bcnt, 40);
        chk("gap0_valid_cycles", v0cnt, 36);
        chk("gap0_contig_run", maxrun0, 36);
        chk("gap0_done_pulses", d0cnt, 3);
        chk("gap0_frames", frames0, 3);

        // Start during bit 5 with another mask must be ignored
        start_burst(8'd2, 12'h0A5);
        repeat (4) @(negedge clk);
        #1;
        start = 1'b1;
        rep = 8'd5;
        mask = 12'hF0F;
        @(negedge clk);
        #1;
        start = 1'b0;
        rep = 8'd0;
        mask = '0;
        wait_drain();
        chk("ign_errbits", errb, 4);
        chk("ign_frames", frames, 2);

        // Abort while frame 2 shows its 7th bit
        start_burst(8'd3, 12'h000);
        repeat (20) @(negedge clk);
        #1;
        abort = 1'b1;
        q.delete();
        @(negedge clk);
        #1;
        abort = 1'b0;
        chk("abort_ctl", {busy, valid, data, done}, 4'b0000);
        chk("abort_frames", frames, 1);
        repeat (8) @(negedge clk);
        #1;
        chk("abort_frames_hold", frames, 1);

        // Asynchronous reset between edges mid-frame
        start_burst(8'd2, 12'h3C0);
        repeat (4) @(negedge clk);
        #1;
        mon_en = 1'b0;
        q.delete();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("areset_ctl", {busy, valid, data, done}, 4'b0000);
        chk("areset_frames", frames, 0);
        chk("areset_errbits", errb, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        start_burst(8'd1, 12'h000);
        wait_drain();
        chk("post_reset_frames", frames, 1);
        chk("post_reset_errbits", errb, 0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
